vga_scan: RTL

- Raster-scan generator and pixel compositor for the pong display, 640x480 at 60 Hz from the 100 MHz board clock.
- Drives the x/y pixel coordinate bus that every glyph, paddle and ball renderer consumes.
- Samples their combined display flag (one bit per pixel) and produces registered hsync, vsync and 12-bit RGB.
- This is the producing and consuming end of the renderers' x/y-in, display-out interface.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/pixel_tick_gen.sv | 30 +++
 rtl/vga_scan.sv | 102 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and colour definitions for the pong raster generator.
// The numbers describe the standard 640x480 at 60 Hz VGA mode.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 12;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t BLACK = 12'h000;
  localparam color_t WHITE = 12'hFFF;

  // Half-open window test used for both visibility and sync pulses.
  function automatic logic in_window(input coord_t val, input coord_t lo, input coord_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to the pixel rate as a one-clock strobe.
// The strobe is registered so the first one appears CLK_DIV clocks after reset.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div    <= '0;
      p_tick <= 1'b0;
    end else begin
      p_tick <= (div == DIV_LAST);
      if (div == DIV_LAST) begin
        div <= '0;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_scan.sv
// Raster scan counters, sync decode and registered pixel compositor for the pong display.
// x/y feed the renderers; their OR-ed display flag comes back as pixel_in one pixel later.
module vga_scan
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic               clk,
  input  logic               reset,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic               p_tick,
  output logic               frame_start,
  input  logic               pixel_in,
  input  logic [COLOR_W-1:0] fg_rgb,
  input  logic [COLOR_W-1:0] bg_rgb,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COLOR_W-1:0] rgb
);

  localparam coord_t H_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS    = COORD_W'(H_ACTIVE);
  localparam coord_t V_VIS    = COORD_W'(V_ACTIVE);
  localparam coord_t HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  coord_t h;
  coord_t v;
  logic   vis;
  logic   hs_n;
  logic   vs_n;
  color_t pix_color;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .p_tick(p_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (p_tick) begin
      if (h == H_LAST) begin
        h <= '0;
        if (v == V_LAST) begin
          v <= '0;
        end else begin
          v <= v + 1'b1;
        end
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign x           = h;
  assign y           = v;
  assign frame_start = p_tick && (h == H_LAST) && (v == V_LAST);

  // Renderers have had CLK_DIV-1 clocks to settle pixel_in for the current h/v.
  always_comb begin
    vis       = (h < H_VIS) && (v < V_VIS);
    hs_n      = !in_window(h, HS_START, HS_END);
    vs_n      = !in_window(v, VS_START, VS_END);
    pix_color = BLACK;
    if (vis) begin
      pix_color = pixel_in ? fg_rgb : bg_rgb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
      rgb      <= BLACK;
    end else if (p_tick) begin
      hsync    <= hs_n;
      vsync    <= vs_n;
      video_on <= vis;
      rgb      <= pix_color;
    end
  end

endmodule
